// File: rtl/sum_accum_pkg.sv
// Shared types and helpers for the frame-sum accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sum_accum_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    // Accumulator width large enough that COUNT maximal samples never overflow.
    function automatic int acc_width(input int in_w, input int count);
        return in_w + $clog2(count);
    endfunction

endpackage

// File: rtl/frame_counter.sv
// Counts accepted samples within a frame; flags the last slot (cnt == COUNT-1).
// Latency: cnt updates on the clock edge after a control pulse; last is combinational on cnt.
// Backpressure: none; the caller only pulses controls on accepted samples.
module frame_counter #(
    parameter  int COUNT = 4,
    localparam int CW    = (COUNT > 1) ? $clog2(COUNT) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          load1,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          last
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins over reload, reload wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load1) begin
            cnt_d = CW'(1);
        end else if (inc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == CW'(COUNT - 1));

endmodule

// File: rtl/sum_accumulator.sv
// Sums frames of COUNT unsigned samples and presents the registered total (early close on flush).
// Latency: out_valid rises one cycle after the last accept or the flush cycle.
// Backpressure: while a result waits, in_ready follows out_ready combinationally (pass-through skid).
module sum_accumulator
    import sum_accum_pkg::*;
#(
    parameter  int IN_WIDTH  = 4,
    parameter  int COUNT     = 4,
    localparam int ACC_WIDTH = acc_width(IN_WIDTH, COUNT),
    localparam int CW        = (COUNT > 1) ? $clog2(COUNT) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_lsb,
    output logic                 out_partial,
    output logic                 out_valid,
    input  logic                 out_ready
);

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
    logic                 partial_q, partial_d;

    logic [CW-1:0]        cnt;
    logic                 last;
    logic                 cnt_inc, cnt_load1, cnt_clr;

    logic                 accept;
    logic                 emit;
    logic [ACC_WIDTH-1:0] in_ext;
    logic [ACC_WIDTH-1:0] acc_sum;

    frame_counter #(.COUNT(COUNT)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .load1 (cnt_load1),
        .clr   (cnt_clr),
        .cnt   (cnt),
        .last  (last)
    );

    // Held low during reset so nothing is taken while the block is cleared.
    assign in_ready = rst_n && ((state_q == ACCUM) || out_ready);
    assign out_valid = (state_q == EMIT);
    assign accept   = in_valid && in_ready;
    assign emit     = out_valid && out_ready;

    // Accepted sample zero-extended; zero when nothing is taken so acc_sum is the running total.
    assign in_ext  = accept ? ACC_WIDTH'(in_data) : '0;
    assign acc_sum = acc_q + in_ext;

    // Frame FSM next-state: a full frame takes priority over flush on the same cycle.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        partial_d  = partial_q;
        cnt_inc    = 1'b0;
        cnt_load1  = 1'b0;
        cnt_clr    = 1'b0;
        unique case (state_q)
            ACCUM: begin
                if (accept && last) begin
                    out_data_d = acc_sum;
                    partial_d  = 1'b0;
                    acc_d      = '0;
                    cnt_clr    = 1'b1;
                    state_d    = EMIT;
                end else if (flush && ((cnt != '0) || accept)) begin
                    out_data_d = acc_sum;
                    partial_d  = 1'b1;
                    acc_d      = '0;
                    cnt_clr    = 1'b1;
                    state_d    = EMIT;
                end else if (accept) begin
                    acc_d   = acc_sum;
                    cnt_inc = 1'b1;
                end
            end
            EMIT: begin
                if (emit) begin
                    if (accept) begin
                        if (COUNT == 1) begin
                            // A single-sample frame closes immediately: keep presenting.
                            out_data_d = in_ext;
                            partial_d  = 1'b0;
                        end else begin
                            acc_d     = in_ext;
                            cnt_load1 = 1'b1;
                            state_d   = ACCUM;
                        end
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State, accumulator and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            out_data_q <= '0;
            partial_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            partial_q  <= partial_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_lsb     = out_data_q[0];
    assign out_partial = partial_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench: reference model feeds a scoreboard, monitors pop on each emit.
// Latency: checks one-cycle result latency and back-to-back single-sample frames.
// Backpressure: holds out_ready low and checks in_ready drop and output stability.
module tb_sum_accumulator;

    typedef struct {
        logic [7:0] data;
        logic       partial;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // Default instance (COUNT = 4)
    logic [3:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       flush = 1'b0;
    logic [5:0] out_data;
    logic       out_lsb;
    logic       out_partial;
    logic       out_valid;
    logic       out_ready = 1'b1;

    // Single-sample-frame instance (COUNT = 1)
    logic [3:0] in1_data = '0;
    logic       in1_valid = 1'b0;
    logic       in1_ready;
    logic       flush1 = 1'b0;
    logic [3:0] out1_data;
    logic       out1_lsb;
    logic       out1_partial;
    logic       out1_valid;
    logic       out1_ready = 1'b1;

    int   n_checks = 0;
    int   n_fail = 0;
    int   emit_cnt = 0;
    int   m_acc = 0;
    int   m_cnt = 0;
    int   snap;
    exp_t sb_q[$];
    exp_t sb1_q[$];
    exp_t mon_e;
    exp_t mon1_e;
    exp_t drv1_e;

    always #5 clk = ~clk;

    sum_accumulator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .out_data    (out_data),
        .out_lsb     (out_lsb),
        .out_partial (out_partial),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    sum_accumulator #(.IN_WIDTH(4), .COUNT(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in1_data),
        .in_valid    (in1_valid),
        .in_ready    (in1_ready),
        .flush       (flush1),
        .out_data    (out1_data),
        .out_lsb     (out1_lsb),
        .out_partial (out1_partial),
        .out_valid   (out1_valid),
        .out_ready   (out1_ready)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Present one sample until accepted (bounded), then update the reference model.
    task automatic send(input int d);
        bit   seen;
        exp_t e;
        seen     = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'(d);
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (in_ready) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk_eq("send_accept", 32'(seen), 1);
        if (seen) begin
            m_acc += d;
            m_cnt++;
            if (m_cnt == 4) begin
                e.data    = 8'(m_acc);
                e.partial = 1'b0;
                sb_q.push_back(e);
                m_acc = 0;
                m_cnt = 0;
            end
        end
    endtask

    // One-cycle flush with no sample; a non-empty frame closes as partial.
    task automatic do_flush();
        exp_t e;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        if (m_cnt > 0) begin
            e.data    = 8'(m_acc);
            e.partial = 1'b1;
            sb_q.push_back(e);
            m_acc = 0;
            m_cnt = 0;
        end
    endtask

    // Scoreboard monitor for the COUNT=4 instance.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            emit_cnt++;
            chk_eq("sb_pending", 32'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk_eq("out_data", 32'(out_data), 32'(mon_e.data));
                chk_eq("out_partial", 32'(out_partial), 32'(mon_e.partial));
                chk_eq("out_lsb", 32'(out_lsb), 32'(mon_e.data[0]));
            end
        end
    end

    // Scoreboard monitor for the COUNT=1 instance.
    always @(negedge clk) begin
        if (out1_valid && out1_ready) begin
            chk_eq("sb1_pending", 32'(sb1_q.size() > 0), 1);
            if (sb1_q.size() > 0) begin
                mon1_e = sb1_q.pop_front();
                chk_eq("c1_out_data", 32'(out1_data), 32'(mon1_e.data));
                chk_eq("c1_out_partial", 32'(out1_partial), 32'(mon1_e.partial));
                chk_eq("c1_out_lsb", 32'(out1_lsb), 32'(mon1_e.data[0]));
            end
        end
    end

    initial begin
        // Reset state
        #12;
        chk_eq("rst_in_ready", 32'(in_ready), 0);
        chk_eq("rst_out_valid", 32'(out_valid), 0);
        chk_eq("rst_out_data", 32'(out_data), 0);
        chk_eq("rst_out_partial", 32'(out_partial), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_eq("rel_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        // Back-to-back frame 3,7,15,1 -> 26, one-cycle valid right after the 4th accept
        send(3); send(7); send(15); send(1);
        @(negedge clk);
        chk_eq("lat_valid", 32'(out_valid), 1);
        @(negedge clk);
        chk_eq("valid_one_cycle", 32'(out_valid), 0);
        @(posedge clk);
        #1;

        // Maximum samples -> 60, no overflow
        for (int i = 0; i < 4; i++) send(15);
        @(posedge clk);
        #1;

        // Partial frame closed by flush -> 14, partial
        send(5); send(9);
        do_flush();
        @(negedge clk);
        chk_eq("flush_valid", 32'(out_valid), 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        // Flush on an empty frame produces nothing
        snap = emit_cnt;
        do_flush();
        repeat (3) @(negedge clk);
        chk_eq("empty_flush_no_out", 32'(emit_cnt), 32'(snap));
        @(posedge clk);
        #1;

        // Backpressure: result waits 5 cycles, stays stable, input stalls
        out_ready = 1'b0;
        send(10); send(11); send(12); send(13);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_eq("bp_in_ready", 32'(in_ready), 0);
            chk_eq("bp_out_valid", 32'(out_valid), 1);
            chk_eq("bp_out_data", 32'(out_data), 46);
            chk_eq("bp_out_partial", 32'(out_partial), 0);
            chk_eq("bp_out_lsb", 32'(out_lsb), 0);
        end
        @(posedge clk);
        #1;
        // Release together with a sample: it opens the next frame (2+1+1+1 = 5)
        out_ready = 1'b1;
        send(2); send(1); send(1); send(1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        // COUNT=1: consecutive results with out_valid continuously high
        for (int k = 1; k <= 3; k++) begin
            in1_valid = 1'b1;
            in1_data  = 4'(k);
            @(negedge clk);
            chk_eq("c1_in_ready", 32'(in1_ready), 1);
            if (k > 1) chk_eq("c1_valid_run", 32'(out1_valid), 1);
            if (in1_ready) begin
                drv1_e.data    = 8'(k);
                drv1_e.partial = 1'b0;
                sb1_q.push_back(drv1_e);
            end
            @(posedge clk);
            #1;
        end
        in1_valid = 1'b0;
        @(negedge clk);
        chk_eq("c1_valid_last", 32'(out1_valid), 1);
        chk_eq("c1_data_last", 32'(out1_data), 3);
        @(negedge clk);
        chk_eq("c1_valid_drop", 32'(out1_valid), 0);
        @(posedge clk);
        #1;

        // Reset mid-frame discards the partial sum
        send(1); send(1);
        rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_out_data", 32'(out_data), 0);
        chk_eq("mid_rst_out_valid", 32'(out_valid), 0);
        chk_eq("mid_rst_out_lsb", 32'(out_lsb), 0);
        chk_eq("mid_rst_partial", 32'(out_partial), 0);
        chk_eq("mid_rst_in_ready", 32'(in_ready), 0);
        m_acc = 0;
        m_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_eq("mid_rel_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send(1);

        repeat (4) @(posedge clk);
        #1;
        chk_eq("sb_drained", 32'(sb_q.size()), 0);
        chk_eq("sb1_drained", 32'(sb1_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
